// File: rtl/dmem_lsu.sv
// Load/store initiator for the 4 KB big-endian data memory; sub-word stores are read-modify-write. Optional DMEM_LSU_ALIGN_CHECK_EN flags misaligned halfword/word accesses.
// Latency accept->resp_valid: load MEM_RD_LAT+1, word store 2, sub-word store MEM_RD_LAT+2, error 1.
// One request in flight; req_ready is low from acceptance until the cycle after resp_valid, and req_valid while busy is ignored.
module dmem_lsu #(
    parameter int MEM_RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [11:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [11:0] mem_addr,
    output logic        mem_wr,
    output logic        mem_r,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t      state;
    logic [1:0]  size_q;
    logic        we_q;
    logic        sgn_q;
    logic [31:0] wdata_q;
    logic [7:0]  cnt;
    logic        req_bad;

    always_comb begin
        req_bad = (req_size == 2'b11);
`ifdef DMEM_LSU_ALIGN_CHECK_EN
        if ((req_size == 2'b01 && req_addr[0]) || (req_size == 2'b10 && req_addr[1:0] != 2'b00))
            req_bad = 1'b1;
`endif
    end

    // Big-endian: the addressed byte/halfword sits at the top of the fetched word.
    function automatic logic [31:0] load_ext(input logic [31:0] rd, input logic [1:0] sz, input logic sg);
        case (sz)
            2'b00:   return {{24{sg & rd[31]}}, rd[31:24]};
            2'b01:   return {{16{sg & rd[31]}}, rd[31:16]};
            default: return rd;
        endcase
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] rd, input logic [31:0] wd, input logic [1:0] sz);
        if (sz == 2'b00)
            return {wd[7:0], rd[23:0]};
        return {wd[15:0], rd[15:0]};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'd0;
            mem_addr   <= 12'd0;
            mem_wr     <= 1'b0;
            mem_r      <= 1'b0;
            mem_wdata  <= 32'd0;
            size_q     <= 2'b00;
            we_q       <= 1'b0;
            sgn_q      <= 1'b0;
            wdata_q    <= 32'd0;
            cnt        <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        size_q    <= req_size;
                        we_q      <= req_we;
                        sgn_q     <= req_signed;
                        wdata_q   <= req_wdata;
                        cnt       <= 8'd0;
                        if (req_bad) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'd0;
                        end else if (!req_we || req_size != 2'b10) begin
                            state    <= RD;
                            mem_r    <= 1'b1;
                            mem_addr <= req_addr;
                        end else begin
                            state     <= WR;
                            mem_wr    <= 1'b1;
                            mem_addr  <= req_addr;
                            mem_wdata <= req_wdata;
                        end
                    end
                end
                RD: begin
                    if (cnt == 8'(MEM_RD_LAT - 1)) begin
                        mem_r <= 1'b0;
                        if (we_q) begin
                            state     <= WR;
                            mem_wr    <= 1'b1;
                            mem_wdata <= store_merge(mem_rdata, wdata_q, size_q);
                        end else begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b0;
                            resp_rdata <= load_ext(mem_rdata, size_q, sgn_q);
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                WR: begin
                    mem_wr     <= 1'b0;
                    state      <= RESP;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= 32'd0;
                end
                default: begin
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    req_ready  <= 1'b1;
                    state      <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu: one instance with MEM_RD_LAT=1 backed by a byte-array memory,
// one with MEM_RD_LAT=3 backed by an address-pattern memory for handshake/latency.
module tb_dmem_lsu;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_valid, req_ready, req_we, req_signed;
    logic [1:0]  req_size;
    logic [11:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [11:0] mem_addr;
    logic        mem_wr, mem_r;
    logic [31:0] mem_wdata, mem_rdata;

    logic        p1_req_valid, p1_req_ready, p1_req_we, p1_req_signed;
    logic [1:0]  p1_req_size;
    logic [11:0] p1_req_addr;
    logic [31:0] p1_req_wdata;
    logic        p1_resp_valid, p1_resp_err;
    logic [31:0] p1_resp_rdata;
    logic [11:0] p1_mem_addr;
    logic        p1_mem_wr, p1_mem_r;
    logic [31:0] p1_mem_wdata, p1_mem_rdata;

    bit [7:0] mem0 [4096];

    assign mem_rdata = {mem0[mem_addr], mem0[mem_addr + 12'd1], mem0[mem_addr + 12'd2], mem0[mem_addr + 12'd3]};
    always @(posedge clk) begin
        if (mem_wr) begin
            mem0[mem_addr]         <= mem_wdata[31:24];
            mem0[mem_addr + 12'd1] <= mem_wdata[23:16];
            mem0[mem_addr + 12'd2] <= mem_wdata[15:8];
            mem0[mem_addr + 12'd3] <= mem_wdata[7:0];
        end
    end

    assign p1_mem_rdata = {p1_mem_addr[7:0], p1_mem_addr[7:0] + 8'd1, p1_mem_addr[7:0] + 8'd2, p1_mem_addr[7:0] + 8'd3};

    dmem_lsu #(.MEM_RD_LAT(1)) u0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
        .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_r(mem_r), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    dmem_lsu #(.MEM_RD_LAT(3)) u1 (
        .clk(clk), .rst(rst),
        .req_valid(p1_req_valid), .req_ready(p1_req_ready), .req_we(p1_req_we), .req_size(p1_req_size),
        .req_signed(p1_req_signed), .req_addr(p1_req_addr), .req_wdata(p1_req_wdata),
        .resp_valid(p1_resp_valid), .resp_rdata(p1_resp_rdata), .resp_err(p1_resp_err),
        .mem_addr(p1_mem_addr), .mem_wr(p1_mem_wr), .mem_r(p1_mem_r), .mem_wdata(p1_mem_wdata), .mem_rdata(p1_mem_rdata)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    int          o_lat, o_wr, o_rd;
    logic        o_err, o_both, o_seen;
    logic [31:0] o_rdata, o_wdata;
    logic [11:0] o_waddr;

    // Issue one request on u0 and record what happens up to resp_valid.
    task automatic op(input logic we, input logic [1:0] sz, input logic sg, input logic [11:0] a, input logic [31:0] wd);
        int guard;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        req_valid = 1'b0;
        o_lat = 1; o_wr = 0; o_rd = 0; o_both = 1'b0; o_seen = 1'b0;
        o_err = 1'b0; o_rdata = 32'hxxxxxxxx; o_wdata = 32'd0; o_waddr = 12'd0;
        guard = 0;
        while (guard < 100) begin
            if (mem_wr) begin
                o_wr++;
                o_wdata = mem_wdata;
                o_waddr = mem_addr;
            end
            if (mem_r) o_rd++;
            if (mem_r && mem_wr) o_both = 1'b1;
            if (resp_valid) begin
                o_seen  = 1'b1;
                o_rdata = resp_rdata;
                o_err   = resp_err;
                break;
            end
            @(negedge clk);
            o_lat++;
            guard++;
        end
        chk("resp_seen", 32'(o_seen), 32'd1);
        chk("r_and_wr_overlap", 32'(o_both), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end

    initial begin
        int   k;
        logic flag;
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0; req_addr = 12'd0; req_wdata = 32'd0;
        p1_req_valid = 1'b0; p1_req_we = 1'b0; p1_req_size = 2'b10; p1_req_signed = 1'b0; p1_req_addr = 12'd0; p1_req_wdata = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp", {30'd0, resp_valid, resp_err}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_mem_ctl", {30'd0, mem_wr, mem_r}, 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        rst = 1'b0;

        op(1'b1, 2'b10, 1'b0, 12'h010, 32'hDEADBEEF);
        chk("sw_latency", 32'(o_lat), 32'd2);
        chk("sw_wr_pulses", 32'(o_wr), 32'd1);
        chk("sw_rd_cycles", 32'(o_rd), 32'd0);
        chk("sw_wdata", o_wdata, 32'hDEADBEEF);
        chk("sw_resp", {o_err, o_rdata[30:0]}, 32'd0);

        op(1'b0, 2'b10, 1'b0, 12'h010, 32'd0);
        chk("lw_latency", 32'(o_lat), 32'd2);
        chk("lw_rdata", o_rdata, 32'hDEADBEEF);
        chk("lw_err", 32'(o_err), 32'd0);

        op(1'b1, 2'b00, 1'b0, 12'h011, 32'h0000005A);
        chk("sb_latency", 32'(o_lat), 32'd3);
        chk("sb_rd_cycles", 32'(o_rd), 32'd1);
        chk("sb_wr_pulses", 32'(o_wr), 32'd1);
        chk("sb_wdata", o_wdata, 32'h5ABEEF00);
        chk("sb_waddr", 32'(o_waddr), 32'h011);

        op(1'b0, 2'b10, 1'b0, 12'h010, 32'd0);
        chk("lw_after_sb", o_rdata, 32'hDE5ABEEF);

        op(1'b1, 2'b10, 1'b0, 12'h020, 32'h80F11234);
        op(1'b0, 2'b00, 1'b1, 12'h020, 32'd0);
        chk("lb_signed", o_rdata, 32'hFFFFFF80);
        op(1'b0, 2'b00, 1'b0, 12'h020, 32'd0);
        chk("lbu", o_rdata, 32'h00000080);
        op(1'b0, 2'b01, 1'b1, 12'h020, 32'd0);
        chk("lh_signed", o_rdata, 32'hFFFF80F1);
        op(1'b0, 2'b01, 1'b0, 12'h020, 32'd0);
        chk("lhu", o_rdata, 32'h000080F1);
        op(1'b0, 2'b10, 1'b1, 12'h020, 32'd0);
        chk("lw_signed_ignored", o_rdata, 32'h80F11234);

        op(1'b1, 2'b01, 1'b0, 12'h020, 32'h1111CAFE);
        chk("sh_wdata", o_wdata, 32'hCAFE1234);
        chk("sh_latency", 32'(o_lat), 32'd3);
        op(1'b0, 2'b10, 1'b0, 12'h020, 32'd0);
        chk("lw_after_sh", o_rdata, 32'hCAFE1234);

        op(1'b0, 2'b11, 1'b0, 12'h010, 32'd0);
        chk("rsvd_err", 32'(o_err), 32'd1);
        chk("rsvd_latency", 32'(o_lat), 32'd1);
        chk("rsvd_no_mem", 32'(o_rd + o_wr), 32'd0);
        chk("rsvd_rdata", o_rdata, 32'd0);

        op(1'b0, 2'b10, 1'b0, 12'h013, 32'd0);
`ifdef DMEM_LSU_ALIGN_CHECK_EN
        chk("mis_lw_err", 32'(o_err), 32'd1);
        chk("mis_lw_latency", 32'(o_lat), 32'd1);
        chk("mis_lw_no_mem", 32'(o_rd + o_wr), 32'd0);
`else
        chk("mis_lw_err", 32'(o_err), 32'd0);
        chk("mis_lw_latency", 32'(o_lat), 32'd2);
        chk("mis_lw_rdata", o_rdata, 32'hEF000000);
`endif

        op(1'b1, 2'b01, 1'b0, 12'hFFE, 32'h00001357);
        chk("wrap_sh_wdata", o_wdata, 32'h13570000);
        chk("wrap_mem_000", 32'(mem0[0]), 32'd0);
        op(1'b0, 2'b01, 1'b0, 12'hFFE, 32'd0);
        chk("wrap_lhu", o_rdata, 32'h00001357);

        // Reset lands while a byte store is in its read phase.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0; req_addr = 12'h020; req_wdata = 32'h77;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rstmid_in_rd", {30'd0, mem_r, req_ready}, 32'd2);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_ctl_drop", {29'd0, mem_r, mem_wr, resp_valid}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid_ready", 32'(req_ready), 32'd1);
        flag = 1'b0;
        repeat (4) begin
            if (mem_wr || resp_valid) flag = 1'b1;
            @(negedge clk);
        end
        chk("rstmid_quiet", 32'(flag), 32'd0);
        chk("rstmid_mem_byte", 32'(mem0[12'h020]), 32'h000000CA);
        op(1'b0, 2'b10, 1'b0, 12'h020, 32'd0);
        chk("rstmid_mem_word", o_rdata, 32'hCAFE1234);

        // MEM_RD_LAT = 3, two loads with req_valid held throughout.
        @(negedge clk);
        p1_req_valid = 1'b1; p1_req_we = 1'b0; p1_req_size = 2'b10; p1_req_addr = 12'h040;
        chk("lat3_ready_idle", 32'(p1_req_ready), 32'd1);
        @(negedge clk);
        p1_req_addr = 12'h044;
        k = 1; flag = 1'b0; o_rd = 0;
        while (k < 30) begin
            if (p1_req_ready) flag = 1'b1;
            if (p1_mem_r) o_rd++;
            if (p1_resp_valid) break;
            @(negedge clk);
            k++;
        end
        chk("lat3_latency", 32'(k), 32'd4);
        chk("lat3_rdata", p1_resp_rdata, 32'h40414243);
        chk("lat3_rd_cycles", 32'(o_rd), 32'd3);
        chk("lat3_ready_busy", 32'(flag), 32'd0);
        @(negedge clk);
        chk("lat3_ready_after", {30'd0, p1_req_ready, p1_mem_r}, 32'd2);
        @(negedge clk);
        p1_req_valid = 1'b0;
        chk("lat3_second_accept", {30'd0, p1_req_ready, p1_mem_r}, 32'd1);
        chk("lat3_second_addr", 32'(p1_mem_addr), 32'h044);
        k = 1;
        while (k < 30 && !p1_resp_valid) begin
            @(negedge clk);
            k++;
        end
        chk("lat3_second_latency", 32'(k), 32'd4);
        chk("lat3_second_rdata", p1_resp_rdata, 32'h44454647);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
